// File: rtl/shared_bus_responder_pkg.sv
// Shared definitions for the shared-bus responder: opcodes, snoop results,
// FSM states, snoop/HITM selection and the line data pattern.
package shared_bus_pkg;

  localparam logic [7:0] OP_NOP        = 8'd0;
  localparam logic [7:0] OP_READ       = 8'd1;
  localparam logic [7:0] OP_WRITE      = 8'd2;
  localparam logic [7:0] OP_RWIM       = 8'd3;
  localparam logic [7:0] OP_INVALIDATE = 8'd4;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'b00,
    SNOOP_HIT   = 2'b01,
    SNOOP_HITM  = 2'b10
  } snoop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Deterministic snoop result from the two address bits above the line offset.
  function automatic snoop_e snoop_select(input logic [1:0] sel);
    case (sel)
      2'b01:   return SNOOP_HIT;
      2'b10:   return SNOOP_HITM;
      default: return SNOOP_NOHIT;
    endcase
  endfunction

  // Operations that fetch a line and hit a modified copy are served
  // cache-to-cache: shorter latency and inverted data.
  function automatic logic hitm_path(input logic [7:0] op, input snoop_e res);
    return ((op == OP_READ) || (op == OP_RWIM)) && (res == SNOOP_HITM);
  endfunction

  function automatic logic known_op(input logic [7:0] op);
    return (op >= OP_READ) && (op <= OP_INVALIDATE);
  endfunction

  // One 32-bit word of the line pattern: line address XOR word index.
  function automatic logic [31:0] pattern_word(input logic [31:0] line_addr,
                                               input logic [31:0] idx,
                                               input logic        invert);
    logic [31:0] w;
    w = line_addr ^ idx;
    return invert ? ~w : w;
  endfunction

endpackage

// File: rtl/shared_bus_responder_if.sv
// L2 shared-bus port bundle. master = L2 initiator, slave = responder.
interface shared_bus_responder_if #(
  parameter int addressSize = 32,
  parameter int lineSize    = 512
);
  logic                   opValid;
  logic                   opReady;
  logic [7:0]             sharedOperationBusOut;
  logic [addressSize-1:0] sharedAddressOut;
  logic [lineSize-1:0]    sharedBusOut;
  logic [1:0]             snoopBusIn;
  logic                   snoopValid;
  logic [lineSize-1:0]    sharedBusIn;
  logic                   dataValid;
  logic                   writeAck;
  logic                   protocolError;

  modport master (
    output opValid, sharedOperationBusOut, sharedAddressOut, sharedBusOut,
    input  opReady, snoopBusIn, snoopValid, sharedBusIn, dataValid, writeAck,
           protocolError
  );

  modport slave (
    input  opValid, sharedOperationBusOut, sharedAddressOut, sharedBusOut,
    output opReady, snoopBusIn, snoopValid, sharedBusIn, dataValid, writeAck,
           protocolError
  );
endinterface

// File: rtl/shared_bus_responder_latency_counter.sv
// 8-bit loadable down-counter timing the gap between snoop and response.
module shared_latency_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic       zero
);
  logic [7:0] count_q;

  // Load on accept, then count down to zero and hold there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && !zero) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign zero = (count_q == 8'd0);
endmodule

// File: rtl/shared_bus_responder.sv
// Responder for the L2 shared-bus port: models remote caches plus memory.
// Optional statistics counters are built when SHARED_BUS_RESPONDER_STATS_EN
// is defined.
module shared_bus_responder
  import shared_bus_pkg::*;
#(
  parameter int addressSize = 32,
  parameter int lineSize    = 512,
  parameter int byteSelect  = 6,
  parameter int memLatency  = 4,
  parameter int hitmLatency = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  shared_bus_responder_if.slave   bus
`ifdef SHARED_BUS_RESPONDER_STATS_EN
  ,
  output logic [31:0]             readCount,
  output logic [31:0]             writeCount,
  output logic [31:0]             rwimCount,
  output logic [31:0]             invalidateCount,
  output logic [31:0]             hitmCount
`endif
);

  // The counter holds L-1 on leaving SNOOP; zero there means L=1.
  localparam logic [7:0] MEM_LOAD  = 8'(memLatency - 1);
  localparam logic [7:0] HITM_LOAD = 8'(hitmLatency - 1);

  state_e              state_q;
  logic                op_ready_q;
  logic                snoop_valid_q;
  snoop_e              snoop_q;
  logic                data_valid_q;
  logic                write_ack_q;
  logic                perr_q;
  logic [lineSize-1:0] data_q;
  logic [7:0]          op_q;
  logic [31:0]         line_addr_q;
  logic                data_inv_q;

  logic [7:0]          op_in;
  snoop_e              snoop_in;
  logic                accept;
  logic                accept_known;
  logic [31:0]         line_addr_d;
  logic [7:0]          lat_load;
  logic                lat_zero;
  logic                lat_en;
  logic                enter_resp;
  logic [lineSize-1:0] line_data;

  assign op_in        = bus.sharedOperationBusOut;
  assign snoop_in     = snoop_select(bus.sharedAddressOut[byteSelect+1:byteSelect]);
  assign accept       = (state_q == ST_IDLE) && bus.opValid && (op_in != OP_NOP);
  assign accept_known = accept && known_op(op_in);
  assign lat_load     = hitm_path(op_in, snoop_in) ? HITM_LOAD : MEM_LOAD;
  assign lat_en       = (state_q == ST_SNOOP) || (state_q == ST_WAIT);
  assign enter_resp   = lat_zero && (((state_q == ST_SNOOP) && (op_q != OP_INVALIDATE))
                                     || (state_q == ST_WAIT));

  // Line address: operation address with the line-offset bits cleared.
  always_comb begin
    line_addr_d = '0;
    for (int b = byteSelect; b < 32; b++) begin
      if (b < addressSize) line_addr_d[b] = bus.sharedAddressOut[b];
    end
  end

  for (genvar gi = 0; gi < lineSize / 32; gi++) begin : g_word
    assign line_data[32*gi +: 32] = pattern_word(line_addr_q, 32'(gi), data_inv_q);
  end

  shared_latency_counter u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (accept_known),
    .load_value (lat_load),
    .enable     (lat_en),
    .zero       (lat_zero)
  );

  // Operation FSM with all bus outputs registered; strobes default low each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_ready_q    <= 1'b1;
      snoop_valid_q <= 1'b0;
      snoop_q       <= SNOOP_NOHIT;
      data_valid_q  <= 1'b0;
      write_ack_q   <= 1'b0;
      perr_q        <= 1'b0;
      data_q        <= '0;
      op_q          <= OP_NOP;
      line_addr_q   <= '0;
      data_inv_q    <= 1'b0;
    end else begin
      snoop_valid_q <= 1'b0;
      snoop_q       <= SNOOP_NOHIT;
      data_valid_q  <= 1'b0;
      write_ack_q   <= 1'b0;
      data_q        <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept_known) begin
            state_q       <= ST_SNOOP;
            op_ready_q    <= 1'b0;
            snoop_valid_q <= 1'b1;
            snoop_q       <= snoop_in;
            op_q          <= op_in;
            line_addr_q   <= line_addr_d;
            data_inv_q    <= hitm_path(op_in, snoop_in);
          end else if (accept) begin
            // Unknown opcode: flag it and stay ready; no snoop is issued.
            perr_q <= 1'b1;
          end
        end
        ST_SNOOP: begin
          if (op_q == OP_INVALIDATE) begin
            state_q    <= ST_IDLE;
            op_ready_q <= 1'b1;
          end else if (lat_zero) begin
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_zero) state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          op_ready_q <= 1'b1;
        end
      endcase
      if (enter_resp) begin
        if (op_q == OP_WRITE) begin
          write_ack_q <= 1'b1;
        end else begin
          data_valid_q <= 1'b1;
          data_q       <= line_data;
        end
      end
    end
  end

  assign bus.opReady       = op_ready_q;
  assign bus.snoopValid    = snoop_valid_q;
  assign bus.snoopBusIn    = snoop_q;
  assign bus.dataValid     = data_valid_q;
  assign bus.writeAck      = write_ack_q;
  assign bus.sharedBusIn   = data_q;
  assign bus.protocolError = perr_q;

`ifdef SHARED_BUS_RESPONDER_STATS_EN
  // Per-type operation counters, bumped on the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readCount       <= 32'd0;
      writeCount      <= 32'd0;
      rwimCount       <= 32'd0;
      invalidateCount <= 32'd0;
      hitmCount       <= 32'd0;
    end else if (accept_known) begin
      case (op_in)
        OP_READ:       readCount       <= readCount + 32'd1;
        OP_WRITE:      writeCount      <= writeCount + 32'd1;
        OP_RWIM:       rwimCount       <= rwimCount + 32'd1;
        OP_INVALIDATE: invalidateCount <= invalidateCount + 32'd1;
        default: ;
      endcase
      if (snoop_in == SNOOP_HITM) hitmCount <= hitmCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_bus_responder.sv
// Randomized scoreboard bench for shared_bus_responder.
`timescale 1ns/1ps
module tb_shared_bus_responder;
  localparam int AW = 32;
  localparam int LW = 512;
  localparam int WORDS = LW / 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  shared_bus_responder_if #(.addressSize(AW), .lineSize(LW)) bus ();

`ifdef SHARED_BUS_RESPONDER_STATS_EN
  logic [31:0] readCount, writeCount, rwimCount, invalidateCount, hitmCount;
`endif

  shared_bus_responder #(
    .addressSize(AW), .lineSize(LW), .byteSelect(6), .memLatency(4), .hitmLatency(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SHARED_BUS_RESPONDER_STATS_EN
    ,
    .readCount       (readCount),
    .writeCount      (writeCount),
    .rwimCount       (rwimCount),
    .invalidateCount (invalidateCount),
    .hitmCount       (hitmCount)
`endif
  );

  typedef struct { int cyc; logic [1:0] res; } snoop_exp_t;
  typedef struct { int cyc; logic ack; logic [LW-1:0] data; } resp_exp_t;

  snoop_exp_t snq[$];
  resp_exp_t  rsq[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int ready_at = 0;
  int ready_skip = -1;
  bit perr_set = 1'b0;
  int perr_cyc = 0;
  int last_acc = 0;
  int m_read = 0, m_write = 0, m_rwim = 0, m_inval = 0, m_hitm = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference snoop table on address bits [7:6].
  function automatic logic [1:0] ref_snoop(input logic [31:0] addr);
    case (addr[7:6])
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] addr, input bit inv);
    logic [LW-1:0] line;
    logic [31:0]   base;
    logic [31:0]   w;
    base = addr & 32'hFFFF_FFC0;
    line = '0;
    for (int i = 0; i < WORDS; i++) begin
      w = base ^ 32'(i);
      line[i*32 +: 32] = inv ? ~w : w;
    end
    return line;
  endfunction

  // Scoreboard monitor: compares outputs against queued expectations each cycle.
  always @(negedge clock) begin
    snoop_exp_t se;
    resp_exp_t  re;
    if (bus.snoopValid) begin
      if (snq.size() == 0) chk("unexpected_snoop", LW'(1), LW'(0));
      else begin
        se = snq.pop_front();
        chk("snoop_cycle", LW'(cyc), LW'(se.cyc));
        chk("snoop_result", LW'(bus.snoopBusIn), LW'(se.res));
      end
    end else begin
      chk("snoop_idle_zero", LW'(bus.snoopBusIn), LW'(0));
      if (snq.size() > 0 && snq[0].cyc <= cyc) begin
        chk("snoop_missing", LW'(0), LW'(1));
        void'(snq.pop_front());
      end
    end
    if (bus.dataValid || bus.writeAck) begin
      if (rsq.size() == 0) chk("unexpected_resp", LW'(1), LW'(0));
      else begin
        re = rsq.pop_front();
        chk("resp_cycle", LW'(cyc), LW'(re.cyc));
        chk("resp_kind", LW'({bus.dataValid, bus.writeAck}), LW'(re.ack ? 2'b01 : 2'b10));
        chk("resp_data", bus.sharedBusIn, re.data);
      end
    end else begin
      chk("data_idle_zero", bus.sharedBusIn, '0);
      if (rsq.size() > 0 && rsq[0].cyc <= cyc) begin
        chk("resp_missing", LW'(0), LW'(1));
        void'(rsq.pop_front());
      end
    end
    if (cyc != ready_skip) chk("op_ready", LW'(bus.opReady), LW'(cyc >= ready_at));
    chk("protocol_error", LW'(bus.protocolError), LW'(perr_set && cyc >= perr_cyc));
  end

  // Present one operation as soon as the responder is ready; garbage while busy.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr);
    int waited;
    int acc;
    int lat;
    logic [1:0] s;
    waited = 0;
    while (1) begin
      @(negedge clock); #1;
      if (bus.opReady === 1'b1) break;
      bus.opValid = 1'($urandom_range(0, 1));
      bus.sharedOperationBusOut = 8'($urandom);
      bus.sharedAddressOut = $urandom;
      bus.sharedBusOut = {WORDS{$urandom}};
      waited++;
      if (waited > 400) begin
        chk("ready_timeout", LW'(0), LW'(1));
        return;
      end
    end
    bus.opValid = 1'b1;
    bus.sharedOperationBusOut = op;
    bus.sharedAddressOut = addr;
    bus.sharedBusOut = {WORDS{$urandom}};
    acc = cyc + 1;
    last_acc = acc;
    s = ref_snoop(addr);
    if (op >= 8'd1 && op <= 8'd4) begin
      snq.push_back('{acc, s});
      if (s == 2'b10) m_hitm++;
      case (op)
        8'd1: m_read++;
        8'd2: m_write++;
        8'd3: m_rwim++;
        default: m_inval++;
      endcase
      if (op == 8'd4) ready_at = acc + 1;
      else begin
        lat = ((op == 8'd1 || op == 8'd3) && s == 2'b10) ? 2 : 4;
        if (op == 8'd2) rsq.push_back('{acc + lat, 1'b1, '0});
        else rsq.push_back('{acc + lat, 1'b0, ref_line(addr, s == 2'b10)});
        ready_at = acc + lat + 1;
      end
    end else if (op != 8'd0) begin
      perr_set = 1'b1;
      perr_cyc = acc;
      ready_skip = acc;
    end
    $display("[TB] issue op=%0d addr=%08h accept_cycle=%0d", op, addr, acc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock); #1;
      bus.opValid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (1) begin
      @(negedge clock); #1;
      bus.opValid = 1'b0;
      if (bus.opReady === 1'b1 && snq.size() == 0 && rsq.size() == 0) break;
      waited++;
      if (waited > 400) begin
        chk("drain_timeout", LW'(0), LW'(1));
        break;
      end
    end
  endtask

  task automatic check_stats();
`ifdef SHARED_BUS_RESPONDER_STATS_EN
    chk("read_count", LW'(readCount), LW'(m_read));
    chk("write_count", LW'(writeCount), LW'(m_write));
    chk("rwim_count", LW'(rwimCount), LW'(m_rwim));
    chk("invalidate_count", LW'(invalidateCount), LW'(m_inval));
    chk("hitm_count", LW'(hitmCount), LW'(m_hitm));
`endif
  endtask

  task automatic check_quiet_outputs();
    chk("rst_op_ready", LW'(bus.opReady), LW'(1));
    chk("rst_snoop_valid", LW'(bus.snoopValid), LW'(0));
    chk("rst_snoop_bus", LW'(bus.snoopBusIn), LW'(0));
    chk("rst_data_valid", LW'(bus.dataValid), LW'(0));
    chk("rst_write_ack", LW'(bus.writeAck), LW'(0));
    chk("rst_protocol_error", LW'(bus.protocolError), LW'(0));
    chk("rst_data", bus.sharedBusIn, '0);
  endtask

  initial begin
    logic [7:0] op;
    int r;
    bus.opValid = 1'b0;
    bus.sharedOperationBusOut = 8'd0;
    bus.sharedAddressOut = '0;
    bus.sharedBusOut = '0;
    repeat (3) @(negedge clock);
    #1;
    check_quiet_outputs();
    check_stats();
    reset = 1'b0;

    // Directed sequence from the plan: READ, RWIM(HITM), WRITE(HIT), INVALIDATE+READ back to back.
    issue(8'd1, 32'h0000_1000);
    issue(8'd3, 32'h0000_1080);
    issue(8'd2, 32'h0000_0040);
    issue(8'd4, 32'h0000_0000);
    issue(8'd1, 32'h0000_0000);
    drain();
    check_stats();
`ifdef SHARED_BUS_RESPONDER_STATS_EN
    chk("plan_read_count", LW'(readCount), LW'(2));
    chk("plan_hitm_count", LW'(hitmCount), LW'(1));
`endif

    // Randomized operations including NOPs, with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? 8'd0 : (r <= 3) ? 8'd1 : (r <= 5) ? 8'd2 : (r <= 7) ? 8'd3 : 8'd4;
      issue(op, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check_stats();

    // Unknown opcodes: sticky error, no snoop; normal traffic continues.
    issue(8'h07, $urandom);
    idle(4);
    issue(8'hFF, $urandom);
    idle(4);
    issue(8'd1, 32'h1234_5680);
    drain();

    // Reset in the middle of a READ (cycle E0+3): no response afterwards.
    issue(8'd1, 32'h0000_2000);
    while (cyc < last_acc + 2) @(negedge clock);
    #1;
    reset = 1'b1;
    bus.opValid = 1'b0;
    snq.delete();
    rsq.delete();
    ready_at = 0;
    ready_skip = -1;
    perr_set = 1'b0;
    m_read = 0; m_write = 0; m_rwim = 0; m_inval = 0; m_hitm = 0;
    #1;
    check_quiet_outputs();
    check_stats();
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    idle(10);

    issue(8'd3, 32'h0000_3080);
    drain();
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
